// File: rtl/port_fifo_dev.sv
// Port-bus responder exposing a TX byte FIFO, an RX byte FIFO, STATUS, SCRATCH and ID
// in a 4-word window. Define PORT_FIFO_DEV_IRQ_EN to add the irq output and STATUS[5:4] enables.
module port_fifo_dev #(
  parameter int                   WORD_SIZE  = 16,
  parameter logic [WORD_SIZE-1:0] BASE_ADDR  = 16'h0010,
  parameter int                   FIFO_DEPTH = 4,
  parameter logic [WORD_SIZE-1:0] DEV_ID     = 16'hC0DE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] portaddr,
  input  logic [WORD_SIZE-1:0] portval,
  input  logic                 portget,
  input  logic                 portset,
  output logic [WORD_SIZE-1:0] portout,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready
`ifdef PORT_FIFO_DEV_IRQ_EN
  ,
  output logic                 irq
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_STATUS  = 2'd1,
    REG_SCRATCH = 2'd2,
    REG_ID      = 2'd3
  } reg_e;

  logic [7:0]           tx_mem [FIFO_DEPTH];
  logic [7:0]           rx_mem [FIFO_DEPTH];
  logic [PW-1:0]        tx_rd, tx_wr, rx_rd, rx_wr;
  logic [CW-1:0]        tx_count, rx_count;
  logic                 txovf, rxunf;
  logic [WORD_SIZE-1:0] scratch;
  logic [WORD_SIZE-1:0] status;
  logic [WORD_SIZE-1:0] rdata;

  logic hit;
  reg_e offset;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push_req, tx_push, tx_pop;
  logic rx_pop_req, rx_pop, rx_push;
  logic status_wr;

  assign hit      = portaddr[WORD_SIZE-1:2] == BASE_ADDR[WORD_SIZE-1:2];
  assign offset   = reg_e'(portaddr[1:0]);

  assign tx_full  = tx_count == CW'(FIFO_DEPTH);
  assign tx_empty = tx_count == '0;
  assign rx_full  = rx_count == CW'(FIFO_DEPTH);
  assign rx_empty = rx_count == '0;

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_mem[tx_rd];
  assign rx_ready = !rx_full;

  // A full FIFO still takes a push when the same edge pops, since the slot frees up.
  assign tx_push_req = portset && hit && offset == REG_DATA;
  assign tx_pop      = tx_valid && tx_ready;
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);

  assign rx_pop_req  = portget && hit && offset == REG_DATA;
  assign rx_pop      = rx_pop_req && !rx_empty;
  assign rx_push     = rx_valid && rx_ready;

  assign status_wr   = portset && hit && offset == REG_STATUS;

`ifdef PORT_FIFO_DEV_IRQ_EN
  logic rxie, txie;
`endif

  always_comb begin
    status        = '0;
    status[0]     = !rx_empty;
    status[1]     = tx_full;
    status[2]     = txovf;
    status[3]     = rxunf;
`ifdef PORT_FIFO_DEV_IRQ_EN
    status[4]     = rxie;
    status[5]     = txie;
`endif
    status[8 +: CW] = rx_count;
  end

  // Read data reflects pre-write state when portget and portset coincide.
  always_comb begin
    rdata = '0;
    if (hit) begin
      unique case (offset)
        REG_DATA:    if (!rx_empty) rdata[7:0] = rx_mem[rx_rd];
        REG_STATUS:  rdata = status;
        REG_SCRATCH: rdata = scratch;
        REG_ID:      rdata = DEV_ID;
      endcase
    end
  end

  // NOTE: FIFO storage is reset too, so tx_data is a defined 0 out of reset rather than X.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) tx_mem[i] <= '0;
      tx_rd    <= '0;
      tx_wr    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wr] <= portval[7:0];
        tx_wr         <= tx_wr + PW'(1);
      end
      if (tx_pop) tx_rd <= tx_rd + PW'(1);
      unique case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CW'(1);
        2'b01:   tx_count <= tx_count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) rx_mem[i] <= '0;
      rx_rd    <= '0;
      rx_wr    <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wr] <= rx_data;
        rx_wr         <= rx_wr + PW'(1);
      end
      if (rx_pop) rx_rd <= rx_rd + PW'(1);
      unique case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CW'(1);
        2'b01:   rx_count <= rx_count - CW'(1);
        default: ;
      endcase
    end
  end

  // Sticky flags: a new set event on the same edge as a write-1-to-clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txovf   <= 1'b0;
      rxunf   <= 1'b0;
      scratch <= '0;
      portout <= '0;
    end else begin
      txovf <= (tx_push_req && !tx_push) || (txovf && !(status_wr && portval[2]));
      rxunf <= (rx_pop_req && rx_empty) || (rxunf && !(status_wr && portval[3]));
      if (portset && hit && offset == REG_SCRATCH) scratch <= portval;
      if (portget) portout <= rdata;
    end
  end

`ifdef PORT_FIFO_DEV_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxie <= 1'b0;
      txie <= 1'b0;
      irq  <= 1'b0;
    end else begin
      if (status_wr) begin
        rxie <= portval[4];
        txie <= portval[5];
      end
      irq <= (rxie && !rx_empty) || (txie && tx_empty);
    end
  end
`endif

endmodule

// File: tb/tb_port_fifo_dev.sv
// Directed bench for port_fifo_dev: a vector table for register/FIFO basics plus
// hand-written sequences for overflow, RX full with simultaneous pop, miss and async reset.
module tb_port_fifo_dev;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] portaddr, portval;
  logic        portget, portset;
  logic [15:0] portout;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int passed = 0;
  int total  = 0;

  port_fifo_dev dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .portaddr (portaddr),
    .portval  (portval),
    .portget  (portget),
    .portset  (portset),
    .portout  (portout),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        get;
    logic        set;
    logic [15:0] addr;
    logic [15:0] val;
    logic        txr;
    logic        rxv;
    logic [7:0]  rxd;
    logic [15:0] exp_out;
    logic        exp_tv;
    logic [7:0]  exp_td;
    logic        exp_rr;
  } vec_t;

  vec_t vecs [23];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [15:0] a);
    portaddr = a;
    portget  = 1'b1;
    tick();
    portget  = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] v);
    portaddr = a;
    portval  = v;
    portset  = 1'b1;
    tick();
    portset  = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    //            get  set  addr     val      txr  rxv  rxd    out      tv   td     rr
    vecs[0]  = '{1'b1, 1'b0, 16'h13, 16'h0000, 1'b0, 1'b0, 8'h00, 16'hC0DE, 1'b0, 8'h00, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 16'h10, 16'h0041, 1'b0, 1'b0, 8'h00, 16'hC0DE, 1'b1, 8'h41, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 16'h10, 16'h0042, 1'b0, 1'b0, 8'h00, 16'hC0DE, 1'b1, 8'h41, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 16'h00, 16'h0000, 1'b1, 1'b0, 8'h00, 16'hC0DE, 1'b1, 8'h42, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 16'h00, 16'h0000, 1'b1, 1'b0, 8'h00, 16'hC0DE, 1'b0, 8'h00, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 16'h00, 16'h0000, 1'b0, 1'b1, 8'h55, 16'hC0DE, 1'b0, 8'h00, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 16'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0055, 1'b0, 8'h00, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 16'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 16'h11, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0008, 1'b0, 8'h00, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 16'h11, 16'h0008, 1'b0, 1'b0, 8'h00, 16'h0008, 1'b0, 8'h00, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 16'h11, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 16'h00, 16'h0000, 1'b0, 1'b1, 8'hA1, 16'h0000, 1'b0, 8'h00, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 16'h00, 16'h0000, 1'b0, 1'b1, 8'hA2, 16'h0000, 1'b0, 8'h00, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 16'h11, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0201, 1'b0, 8'h00, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 16'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h00A1, 1'b0, 8'h00, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 16'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h00A2, 1'b0, 8'h00, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 16'h12, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h00A2, 1'b0, 8'h00, 1'b1};
    vecs[17] = '{1'b1, 1'b0, 16'h12, 16'h0000, 1'b0, 1'b0, 8'h00, 16'hBEEF, 1'b0, 8'h00, 1'b1};
    vecs[18] = '{1'b1, 1'b1, 16'h12, 16'h1111, 1'b0, 1'b0, 8'h00, 16'hBEEF, 1'b0, 8'h00, 1'b1};
    vecs[19] = '{1'b1, 1'b0, 16'h12, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h1111, 1'b0, 8'h00, 1'b1};
    vecs[20] = '{1'b1, 1'b0, 16'h20, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1};
    vecs[21] = '{1'b0, 1'b1, 16'h13, 16'h1234, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1};
    vecs[22] = '{1'b1, 1'b0, 16'h13, 16'h0000, 1'b0, 1'b0, 8'h00, 16'hC0DE, 1'b0, 8'h00, 1'b1};

    reset_n  = 1'b0;
    portaddr = '0;
    portval  = '0;
    portget  = 1'b0;
    portset  = 1'b0;
    tx_ready = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    check("reset portout", portout, 16'h0000);
    check("reset tx_valid", 16'(tx_valid), 16'h0000);
    check("reset rx_ready", 16'(rx_ready), 16'h0001);
    check("reset tx_data", 16'(tx_data), 16'h0000);

    foreach (vecs[i]) begin
      portget  = vecs[i].get;
      portset  = vecs[i].set;
      portaddr = vecs[i].addr;
      portval  = vecs[i].val;
      tx_ready = vecs[i].txr;
      rx_valid = vecs[i].rxv;
      rx_data  = vecs[i].rxd;
      tick();
      check($sformatf("vec%0d portout", i), portout, vecs[i].exp_out);
      check($sformatf("vec%0d tx_valid", i), 16'(tx_valid), 16'(vecs[i].exp_tv));
      check($sformatf("vec%0d rx_ready", i), 16'(rx_ready), 16'(vecs[i].exp_rr));
      if (vecs[i].exp_tv)
        check($sformatf("vec%0d tx_data", i), 16'(tx_data), 16'(vecs[i].exp_td));
    end
    portget  = 1'b0;
    portset  = 1'b0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;

    // TX overflow, W1C, and simultaneous TXOVF/RXUNF set events
    for (int i = 1; i <= 5; i++) bus_write(16'h10, 16'(i));
    bus_read(16'h11);
    check("ovf status", portout, 16'h0006);
    bus_write(16'h11, 16'h0004);
    bus_read(16'h11);
    check("ovf cleared", portout, 16'h0002);
    portaddr = 16'h10;
    portval  = 16'h0099;
    portget  = 1'b1;
    portset  = 1'b1;
    tick();
    portget  = 1'b0;
    portset  = 1'b0;
    check("get+set empty rx", portout, 16'h0000);
    bus_read(16'h11);
    check("both sticky", portout, 16'h000E);
    bus_write(16'h11, 16'h000C);
    bus_read(16'h11);
    check("both cleared", portout, 16'h0002);
    tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain%0d valid", i), 16'(tx_valid), 16'h0001);
      check($sformatf("drain%0d data", i), 16'(tx_data), 16'(i));
      tick();
    end
    check("drained", 16'(tx_valid), 16'h0000);
    tx_ready = 1'b0;

    // RX full: CPU pop with source waiting; source byte enters on the following edge
    rx_send(8'h11);
    rx_send(8'h22);
    rx_send(8'h33);
    rx_send(8'h44);
    check("rx full ready", 16'(rx_ready), 16'h0000);
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    portaddr = 16'h10;
    portget  = 1'b1;
    tick();
    portget  = 1'b0;
    check("pop while full", portout, 16'h0011);
    check("ready after pop", 16'(rx_ready), 16'h0001);
    tick();
    rx_valid = 1'b0;
    check("refilled ready", 16'(rx_ready), 16'h0000);
    bus_read(16'h11);
    check("rx count 4", portout, 16'h0401);
    bus_read(16'h10);
    check("rx order 1", portout, 16'h0022);
    bus_read(16'h10);
    check("rx order 2", portout, 16'h0033);
    bus_read(16'h10);
    check("rx order 3", portout, 16'h0044);
    bus_read(16'h10);
    check("rx order 4", portout, 16'h0055);

    // Miss after valid read: portout 0 and no FIFO side effect
    rx_send(8'h77);
    bus_read(16'h12);
    check("scratch read", portout, 16'h1111);
    bus_read(16'h20);
    check("miss read", portout, 16'h0000);
    bus_read(16'h11);
    check("miss no effect", portout, 16'h0101);
    bus_read(16'h10);
    check("byte survives miss", portout, 16'h0077);

    // Asynchronous reset mid-cycle
    bus_write(16'h10, 16'h00AB);
    for (int i = 0; i < 4; i++) rx_send(8'(i + 1));
    bus_read(16'h13);
    check("pre-reset portout", portout, 16'hC0DE);
    check("pre-reset tx_valid", 16'(tx_valid), 16'h0001);
    check("pre-reset rx_ready", 16'(rx_ready), 16'h0000);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async portout", portout, 16'h0000);
    check("async tx_valid", 16'(tx_valid), 16'h0000);
    check("async rx_ready", 16'(rx_ready), 16'h0001);
    check("async tx_data", 16'(tx_data), 16'h0000);
    tick();
    reset_n = 1'b1;
    tick();
    bus_read(16'h11);
    check("post-reset status", portout, 16'h0000);
    bus_read(16'h12);
    check("post-reset scratch", portout, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
